// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier.
// Results drive the register-file write port directly through registered outputs.
module exec_unit #(
  parameter int DATA_WIDTH    = 36,
  parameter int ADDRESS_WIDTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2:0]               i_op,
  input  logic [ADDRESS_WIDTH-1:0] i_rd,
  input  logic [DATA_WIDTH-1:0]    i_rs1_data,
  input  logic [DATA_WIDTH-1:0]    i_rs2_data,
  output logic [ADDRESS_WIDTH-1:0] o_rd,
  output logic [DATA_WIDTH-1:0]    o_wdata,
  output logic                     o_wen
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    a_q, a_d;
  logic [DATA_WIDTH-1:0]    b_q, b_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] mul_rd_q, mul_rd_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     wen_q, wen_d;

  logic [DATA_WIDTH-1:0]    alu_res;
  logic [DATA_WIDTH-1:0]    acc_sum;
  logic [5:0]               shamt;
  logic                     shift_oob;
  op_e                      op;

  assign op        = op_e'(i_op);
  assign shamt     = i_rs2_data[5:0];
  // Only the low six bits of the shift amount count; anything past the width flushes to zero.
  assign shift_oob = (shamt >= 6'(DATA_WIDTH));
  assign acc_sum   = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    unique case (op)
      OP_ADD: alu_res = i_rs1_data + i_rs2_data;
      OP_SUB: alu_res = i_rs1_data - i_rs2_data;
      OP_AND: alu_res = i_rs1_data & i_rs2_data;
      OP_OR:  alu_res = i_rs1_data | i_rs2_data;
      OP_XOR: alu_res = i_rs1_data ^ i_rs2_data;
      OP_SHL: alu_res = shift_oob ? '0 : (i_rs1_data << shamt);
      OP_SHR: alu_res = shift_oob ? '0 : (i_rs1_data >> shamt);
      OP_MUL: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_rd_d = mul_rd_q;
    rd_d     = rd_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (op == OP_MUL) begin
            a_d      = i_rs1_data;
            b_d      = i_rs2_data;
            acc_d    = '0;
            cnt_d    = CNT_W'(DATA_WIDTH);
            mul_rd_d = i_rd;
            state_d  = S_MUL;
          end else begin
            wdata_d = alu_res;
            rd_d    = i_rd;
            wen_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        // The last iteration's sum goes straight to the write port so the result lands DATA_WIDTH edges after accept.
        if (cnt_q == CNT_W'(1)) begin
          wdata_d = acc_sum;
          rd_d    = mul_rd_q;
          wen_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (i_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_rd_q <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mul_rd_q <= mul_rd_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
    end
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_rd    = rd_q;
  assign o_wdata = wdata_q;
  assign o_wen   = wen_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU vector table plus multiply latency,
// back-pressure and reset-abort sequences.
module tb_exec_unit;

  localparam int DW = 36;
  localparam int AW = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [2:0]    op;
  logic [AW-1:0] rd;
  logic [DW-1:0] rs1;
  logic [DW-1:0] rs2;
  logic [AW-1:0] o_rd;
  logic [DW-1:0] o_wdata;
  logic          o_wen;

  int errors = 0;
  int checks = 0;

  exec_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (valid),
    .o_ready    (ready),
    .i_op       (op),
    .i_rd       (rd),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .o_rd       (o_rd),
    .o_wdata    (o_wdata),
    .o_wen      (o_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [AW-1:0] r,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    valid = 1'b1;
    op    = o;
    rd    = r;
    rs1   = a;
    rs2   = b;
  endtask

  // Accept a MUL, optionally hold an ADD 5+6 on the inputs while busy,
  // then measure latency, ready-low span and the result.
  task automatic run_mul(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] r, input logic [DW-1:0] exp, input bit hold_add);
    int lat;
    int low;
    drive(OP_MUL, r, a, b);
    step();
    if (hold_add) drive(OP_ADD, 2'd2, 36'd5, 36'd6);
    else valid = 1'b0;
    lat = 0;
    low = 0;
    while (!o_wen && lat < 60) begin
      if (!ready) low++;
      step();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(DW));
    check({name, " ready_low"}, 64'(low), 64'(DW));
    check({name, " wen"}, 64'(o_wen), 64'd1);
    check({name, " wdata"}, 64'(o_wdata), 64'(exp));
    check({name, " rd"}, 64'(o_rd), 64'(r));
    check({name, " ready_back"}, 64'(ready), 64'd1);
    step();
    if (hold_add) begin
      valid = 1'b0;
      check({name, " add_wen"}, 64'(o_wen), 64'd1);
      check({name, " add_wdata"}, 64'(o_wdata), 64'hB);
      check({name, " add_rd"}, 64'(o_rd), 64'd2);
      step();
    end
    check({name, " wen_single"}, 64'(o_wen), 64'd0);
  endtask

  initial begin
    int wen_seen;

    vecs[0]  = '{"add",       OP_ADD, 2'd1, 36'h11,        36'h22,        36'h33};
    vecs[1]  = '{"sub_wrap",  OP_SUB, 2'd2, 36'h0,         36'h1,         36'hFFFFFFFFF};
    vecs[2]  = '{"xor",       OP_XOR, 2'd3, 36'hFFFFFFFFF, 36'h123456789, 36'hEDCBA9876};
    vecs[3]  = '{"and",       OP_AND, 2'd0, 36'hF0F0F0F0F, 36'h0FF00FF00, 36'h00F000F00};
    vecs[4]  = '{"or",        OP_OR,  2'd1, 36'hF0F0F0F0F, 36'h0FF00FF00, 36'hFFF0FFF0F};
    vecs[5]  = '{"add_wrap",  OP_ADD, 2'd2, 36'hFFFFFFFFF, 36'h2,         36'h1};
    vecs[6]  = '{"shl_35",    OP_SHL, 2'd3, 36'h1,         36'd35,        36'h800000000};
    vecs[7]  = '{"shl_36",    OP_SHL, 2'd0, 36'h1,         36'd36,        36'h0};
    vecs[8]  = '{"shr_35",    OP_SHR, 2'd1, 36'h800000000, 36'd35,        36'h1};
    vecs[9]  = '{"shr_63",    OP_SHR, 2'd2, 36'hFFFFFFFFF, 36'd63,        36'h0};
    vecs[10] = '{"shl_upper", OP_SHL, 2'd3, 36'h1,         36'h40,        36'h1};
    vecs[11] = '{"shr_4",     OP_SHR, 2'd0, 36'h123456789, 36'd4,         36'h012345678};

    // Reset with an ADD presented: reset must win over the accept.
    rst = 1'b1;
    drive(OP_ADD, 2'd3, 36'h1, 36'h1);
    step();
    rst = 1'b0;
    valid = 1'b0;
    check("rst ready", 64'(ready), 64'd1);
    check("rst wen", 64'(o_wen), 64'd0);
    check("rst wdata", 64'(o_wdata), 64'd0);
    check("rst rd", 64'(o_rd), 64'd0);
    step();
    check("idle wen", 64'(o_wen), 64'd0);

    // Back-to-back ALU vectors: one writeback per edge.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b);
      step();
      check({vecs[i].name, " wen"}, 64'(o_wen), 64'd1);
      check({vecs[i].name, " wdata"}, 64'(o_wdata), 64'(vecs[i].exp));
      check({vecs[i].name, " rd"}, 64'(o_rd), 64'(vecs[i].rd));
      check({vecs[i].name, " ready"}, 64'(ready), 64'd1);
    end
    valid = 1'b0;
    step();
    check("no_accept wen", 64'(o_wen), 64'd0);

    run_mul("mul_x3", 36'h123456789, 36'd3, 2'd0, 36'h369D0369B, 1'b0);
    run_mul("mul_ones", 36'hFFFFFFFFF, 36'hFFFFFFFFF, 2'd3, 36'h000000001, 1'b0);
    run_mul("mul_bp", 36'h123456789, 36'd3, 2'd1, 36'h369D0369B, 1'b1);

    // Reset ten cycles into a MUL aborts it with no writeback.
    drive(OP_MUL, 2'd1, 36'h7, 36'h9);
    step();
    valid = 1'b0;
    wen_seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (o_wen) wen_seen++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort ready", 64'(ready), 64'd1);
    check("abort wen", 64'(o_wen), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (o_wen) wen_seen++;
      step();
    end
    check("abort no_wen", 64'(wen_seen), 64'd0);
    drive(OP_ADD, 2'd2, 36'd5, 36'd6);
    step();
    valid = 1'b0;
    check("post_abort wen", 64'(o_wen), 64'd1);
    check("post_abort wdata", 64'(o_wdata), 64'hB);
    check("post_abort rd", 64'(o_rd), 64'd2);
    step();
    check("post_abort wen_off", 64'(o_wen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
